ex_shift_alu_stage: RTL and testbench

Execute-stage datapath plus EX/MEM output buffer for the 16-bit CPU. Takes decoded operands from ID/EX and computes the ALU or shift result. The logical right shift uses the team's existing 16-bit logical right shifter; the other shift and rotate paths are built locally. Results are held in a two-entry valid/ready skid buffer so upstream can be stalled by the memory stage without combinational ready paths.

---
 rtl/ex_shift_alu_stage.sv | 173 +++++++++++++++++
 tb/tb_ex_shift_alu_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_shift_alu_stage.sv
// Execute stage: ALU/shift datapath feeding a two-entry valid/ready
// skid buffer (main register drives out_*, skid register absorbs one op
// while downstream stalls). in_ready is a pure flop output.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high; valid/data hold stable until accepted, and ready never
// depends combinationally on valid on the same side.

// Logical right shifter (reused SRL block).
module lsr16 (
  input  logic [15:0] a,
  input  logic [3:0]  sh,
  output logic [15:0] y
);
  // Four-stage logarithmic barrel shift, zero fill.
  always_comb begin
    y = a;
    if (sh[0]) y = {1'b0, y[15:1]};
    if (sh[1]) y = {2'b0, y[15:2]};
    if (sh[2]) y = {4'b0, y[15:4]};
    if (sh[3]) y = {8'b0, y[15:8]};
  end
endmodule

module ex_shift_alu_stage #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_rd,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_rd,
  output logic              out_wr_en,
  output logic              out_zero,
  output logic              out_ovf
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [2:0]        rd;
    logic              wr_en;
    logic              zero;
    logic              ovf;
  } entry_t;

  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W-1:0]   diff_w;
  logic [2*DATA_W-1:0] rol_w;
  logic [2*DATA_W-1:0] ror_w;
  logic [DATA_W-1:0]   srl_w;
  logic [DATA_W-1:0]   res_c;
  logic                ovf_c;
  entry_t              new_e;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept, pop;

  assign shamt = in_b[SHAMT_W-1:0];

  lsr16 u_srl (
    .a  (in_a),
    .sh (shamt),
    .y  (srl_w)
  );

  // ALU / shifter result and flags for the op being presented.
  always_comb begin
    sum_w  = {1'b0, in_a} + {1'b0, in_b};
    diff_w = in_a - in_b;
    // Rotates via a doubled operand so amount 0 falls out naturally.
    rol_w  = {in_a, in_a} << shamt;
    ror_w  = {in_a, in_a} >> shamt;
    res_c  = '0;
    ovf_c  = 1'b0;
    case (in_op)
      4'd0: begin
        res_c = sum_w[DATA_W-1:0];
        ovf_c = (in_a[DATA_W-1] == in_b[DATA_W-1]) &&
                (sum_w[DATA_W-1] != in_a[DATA_W-1]);
      end
      4'd1: begin
        res_c = diff_w;
        ovf_c = (in_a[DATA_W-1] != in_b[DATA_W-1]) &&
                (diff_w[DATA_W-1] != in_a[DATA_W-1]);
      end
      4'd2:  res_c = in_a & in_b;
      4'd3:  res_c = in_a | in_b;
      4'd4:  res_c = in_a ^ in_b;
      4'd5:  res_c = in_a & ~in_b;
      4'd6:  res_c = rol_w[2*DATA_W-1:DATA_W];
      4'd7:  res_c = in_a << shamt;
      4'd8:  res_c = ror_w[DATA_W-1:0];
      4'd9:  res_c = srl_w;
      4'd10: res_c = $signed(in_a) >>> shamt;
      4'd11: res_c = in_b;
      4'd12: res_c = {{(DATA_W-1){1'b0}}, (in_a == in_b)};
      4'd13: res_c = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'd14: res_c = {{(DATA_W-1){1'b0}}, ($signed(in_a) <= $signed(in_b))};
      default: res_c = {{(DATA_W-1){1'b0}}, sum_w[DATA_W]};
    endcase
    new_e.result = res_c;
    new_e.rd     = in_rd;
    new_e.wr_en  = in_wr_en;
    new_e.zero   = (res_c == '0);
    new_e.ovf    = ovf_c;
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = main_valid_q & out_ready;

  // Next-state for main/skid entries; skid always drains ahead of new ops.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = new_e;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = new_e;
      end
    end else if (accept) begin
      skid_d       = new_e;
      skid_valid_d = 1'b1;
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_wr_en  = main_q.wr_en;
  assign out_zero   = main_q.zero;
  assign out_ovf    = main_q.ovf;

endmodule

// File: tb/tb_ex_shift_alu_stage.sv
// Directed bench for ex_shift_alu_stage: reset state, opcode vectors,
// backpressure ordering through the skid buffer, and flush behaviour.
module tb_ex_shift_alu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_rd;
  logic        in_wr_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wr_en;
  logic        out_zero;
  logic        out_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
    OP_OR = 4'd3, OP_XOR = 4'd4, OP_ANDN = 4'd5, OP_ROL = 4'd6,
    OP_SLL = 4'd7, OP_ROR = 4'd8, OP_SRL = 4'd9, OP_SRA = 4'd10,
    OP_PASSB = 4'd11, OP_SEQ = 4'd12, OP_SLT = 4'd13, OP_SLE = 4'd14,
    OP_SCO = 4'd15;

  ex_shift_alu_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .in_wr_en   (in_wr_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wr_en  (out_wr_en),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] rd,
                          input logic wr);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    in_wr_en = wr;
  endtask

  // Issue one op with downstream ready, check it one cycle later, then drain.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic exp_zero,
                        input logic exp_ovf);
    out_ready = 1'b1;
    drive_op(op, a, b, 3'd5, 1'b1);
    step();
    in_valid = 1'b0;
    check({tag, ".valid"}, {15'b0, out_valid}, 16'h0001);
    check({tag, ".result"}, out_result, exp_res);
    check({tag, ".zero"}, {15'b0, out_zero}, {15'b0, exp_zero});
    check({tag, ".ovf"}, {15'b0, out_ovf}, {15'b0, exp_ovf});
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_rd = '0; in_wr_en = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst.out_valid", {15'b0, out_valid}, 16'h0000);
    check("rst.in_ready",  {15'b0, in_ready},  16'h0001);
    check("rst.result",    out_result,         16'h0000);
    check("rst.wr_en",     {15'b0, out_wr_en}, 16'h0000);
    check("rst.zero_ovf",  {14'b0, out_zero, out_ovf}, 16'h0000);

    // ADD with overflow, also checking passthrough fields.
    out_ready = 1'b1;
    drive_op(OP_ADD, 16'h7FFF, 16'h0001, 3'd3, 1'b1);
    step();
    in_valid = 1'b0;
    check("add.valid",  {15'b0, out_valid}, 16'h0001);
    check("add.result", out_result, 16'h8000);
    check("add.ovf",    {15'b0, out_ovf},  16'h0001);
    check("add.zero",   {15'b0, out_zero}, 16'h0000);
    check("add.rd",     {13'b0, out_rd},   16'h0003);
    check("add.wr_en",  {15'b0, out_wr_en}, 16'h0001);
    step();
    check("idle.valid", {15'b0, out_valid}, 16'h0000);

    run_op("sub_eq",   OP_SUB,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);
    run_op("sub_ovf",  OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_op("add_neg",  OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    run_op("and",      OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0);
    run_op("or",       OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0);
    run_op("xor",      OP_XOR,  16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);
    run_op("andn",     OP_ANDN, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0);
    run_op("srl15",    OP_SRL,  16'h8001, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    run_op("sra3",     OP_SRA,  16'h8001, 16'h0003, 16'hF000, 1'b0, 1'b0);
    run_op("ror1",     OP_ROR,  16'h8001, 16'h0001, 16'hC000, 1'b0, 1'b0);
    run_op("rol4",     OP_ROL,  16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0);
    run_op("sll0",     OP_SLL,  16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0);
    run_op("sll4",     OP_SLL,  16'h8001, 16'hFFF4, 16'h0010, 1'b0, 1'b0);
    run_op("sra0",     OP_SRA,  16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0);
    run_op("ror0",     OP_ROR,  16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0);
    run_op("rol0",     OP_ROL,  16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0);
    run_op("srl0",     OP_SRL,  16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0);
    run_op("sra15",    OP_SRA,  16'h8001, 16'h000F, 16'hFFFF, 1'b0, 1'b0);
    run_op("passb",    OP_PASSB,16'h1111, 16'hABCD, 16'hABCD, 1'b0, 1'b0);
    run_op("slt_t",    OP_SLT,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run_op("slt_f",    OP_SLT,  16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op("sle_eq",   OP_SLE,  16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0);
    run_op("sco",      OP_SCO,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run_op("sco_no",   OP_SCO,  16'h7FFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("seq_f",    OP_SEQ,  16'h00A0, 16'h00A1, 16'h0000, 1'b1, 1'b0);
    run_op("seq_t",    OP_SEQ,  16'h00A0, 16'h00A0, 16'h0001, 1'b0, 1'b0);

    // Backpressure: A, B, C back-to-back with downstream stalled.
    out_ready = 1'b0;
    drive_op(OP_ADD, 16'h0001, 16'h0002, 3'd1, 1'b1);   // A -> 0x0003
    step();
    check("bp.a_main", out_result, 16'h0003);
    check("bp.rdy_a",  {15'b0, in_ready}, 16'h0001);
    drive_op(OP_XOR, 16'hF0F0, 16'h0FF0, 3'd2, 1'b0);   // B -> 0xFF00
    step();
    check("bp.rdy_b",  {15'b0, in_ready}, 16'h0000);
    check("bp.a_hold", out_result, 16'h0003);
    drive_op(OP_OR, 16'h0003, 16'h0400, 3'd4, 1'b1);    // C -> 0x0403
    step();
    check("bp.c_held", {15'b0, in_ready}, 16'h0000);
    check("bp.a_hold2", out_result, 16'h0003);
    check("bp.a_rd",   {13'b0, out_rd}, 16'h0001);
    out_ready = 1'b1;
    step();
    check("bp.b_out",  out_result, 16'hFF00);
    check("bp.b_rd",   {13'b0, out_rd}, 16'h0002);
    check("bp.b_valid", {15'b0, out_valid}, 16'h0001);
    check("bp.rdy_back", {15'b0, in_ready}, 16'h0001);
    step();
    in_valid = 1'b0;
    check("bp.c_out",  out_result, 16'h0403);
    check("bp.c_rd",   {13'b0, out_rd}, 16'h0004);
    check("bp.c_valid", {15'b0, out_valid}, 16'h0001);
    step();
    check("bp.drained", {15'b0, out_valid}, 16'h0000);

    // Flush with both entries full and an op presented.
    out_ready = 1'b0;
    drive_op(OP_PASSB, 16'h0000, 16'h1111, 3'd1, 1'b1);
    step();
    drive_op(OP_PASSB, 16'h0000, 16'h2222, 3'd2, 1'b1);
    step();
    check("fl.full", {15'b0, in_ready}, 16'h0000);
    drive_op(OP_PASSB, 16'h0000, 16'h3333, 3'd3, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl.valid",  {15'b0, out_valid}, 16'h0000);
    check("fl.ready",  {15'b0, in_ready},  16'h0001);
    step();
    check("fl.no_ghost", {15'b0, out_valid}, 16'h0000);
    out_ready = 1'b1;
    drive_op(OP_PASSB, 16'h0000, 16'h4444, 3'd6, 1'b1);
    step();
    in_valid = 1'b0;
    check("fl.next_valid", {15'b0, out_valid}, 16'h0001);
    check("fl.next_res",   out_result, 16'h4444);
    step();

    // Flush while idle and ready: presented op is dropped.
    drive_op(OP_PASSB, 16'h0000, 16'h5555, 3'd7, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl2.dropped", {15'b0, out_valid}, 16'h0000);
    step();
    check("fl2.still", {15'b0, out_valid}, 16'h0000);

    // Reset mid-operation discards entries.
    out_ready = 1'b0;
    drive_op(OP_PASSB, 16'h0000, 16'h6666, 3'd1, 1'b1);
    step();
    drive_op(OP_PASSB, 16'h0000, 16'h7777, 3'd1, 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2.valid",  {15'b0, out_valid}, 16'h0000);
    check("rst2.ready",  {15'b0, in_ready},  16'h0001);
    check("rst2.result", out_result, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
